// File: rtl/jtyiear_obj_draw.sv
// Object line-buffer draw stage: fetches one 16-pixel sprite row from SDRAM, writes it into
// the back half of a ping-pong 256x4 line buffer and plays back the front half at pxl_cen.
module jtyiear_obj_draw #(
    parameter logic [7:0] HOFFSET = 8'd0,
    parameter bit         ERASE   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pxl_cen,
    input  logic        hinit,
    input  logic        LHBL,
    input  logic [8:0]  hdump,
    input  logic        flip,
    input  logic        draw,
    input  logic [8:0]  code,
    input  logic [3:0]  row,
    input  logic [7:0]  xpos,
    input  logic        hflip,
    input  logic        vflip,
    output logic        busy,
    output logic        rom_cs,
    output logic [13:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        rom_ok,
    output logic [3:0]  pxl
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAW} state_t;

    state_t      state, state_nxt;

    logic [8:0]  code_l;
    logic [3:0]  row_l;
    logic [7:0]  xpos_l;
    logic        hflip_l, vflip_l;
    logic [31:0] data_l;
    logic        half;
    logic [2:0]  cnt;
    logic        cs_q;
    logic        bank;

    logic        accept, ok_take, abort, wr_en, erase_en;
    logic [2:0]  nib_idx;
    logic [3:0]  nib;
    logic [7:0]  waddr, raddr;
    logic        unused_hdump;

    logic [3:0]  mem0 [256];
    logic [3:0]  mem1 [256];

    assign unused_hdump = hdump[8];
    assign abort        = hinit & busy;
    assign raddr        = hdump[7:0] ^ {8{flip}};
    assign erase_en     = ERASE && pxl_cen && LHBL;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ok_take   = 1'b0;
        wr_en     = 1'b0;
        nib_idx   = hflip_l ? ~cnt : cnt;
        nib       = data_l[{nib_idx, 2'b00} +: 4];
        waddr     = xpos_l + HOFFSET + {4'd0, half, cnt};
        case (state)
            IDLE:  if (draw) begin
                       accept    = 1'b1;
                       state_nxt = FETCH;
                   end
            FETCH: state_nxt = WAIT;
            // cs_q rejects an rom_ok that arrives on the very first clk of the request
            WAIT:  if (rom_ok && cs_q) begin
                       ok_take   = 1'b1;
                       state_nxt = DRAW;
                   end
            DRAW:  begin
                       wr_en = |nib;
                       if (&cnt) state_nxt = half ? IDLE : FETCH;
                   end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
            accept    = 1'b0;
            ok_take   = 1'b0;
            wr_en     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            cs_q     <= 1'b0;
            bank     <= 1'b0;
            half     <= 1'b0;
            cnt      <= '0;
        end else begin
            busy   <= state_nxt != IDLE;
            rom_cs <= state_nxt == WAIT;
            cs_q   <= rom_cs;
            if (hinit) bank <= ~bank;
            if (state == FETCH && !abort)
                rom_addr <= {code_l, row_l ^ {4{vflip_l}}, half ^ hflip_l};
            if (accept) half <= 1'b0;
            if (ok_take) cnt <= '0;
            if (state == DRAW && !abort) begin
                cnt <= cnt + 3'd1;
                if (&cnt) half <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            code_l  <= code;
            row_l   <= row;
            xpos_l  <= xpos;
            hflip_l <= hflip;
            vflip_l <= vflip;
        end
        if (ok_take) data_l <= rom_data;
    end

    // Each bank has a single write port: draw when it is the back bank, erase when in front
    always_ff @(posedge clk) begin
        if (bank) begin
            if (wr_en) mem0[waddr] <= nib;
        end else if (erase_en) begin
            mem0[raddr] <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!bank) begin
            if (wr_en) mem1[waddr] <= nib;
        end else if (erase_en) begin
            mem1[raddr] <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)       pxl <= '0;
        else if (pxl_cen) pxl <= LHBL ? (bank ? mem1[raddr] : mem0[raddr]) : '0;
    end

endmodule

// File: tb/tb_jtyiear_obj_draw.sv
// Bench for jtyiear_obj_draw: directed and random sprite rows, SDRAM responder with
// configurable latency, and a per-line pixel model replayed against obj_pxl.
module tb_jtyiear_obj_draw;

    localparam logic [7:0] HOFF = 8'd0;

    logic        clk = 1'b0;
    logic        rst_n, pxl_cen, hinit, LHBL, flip, draw, hflip, vflip, rom_ok;
    logic        busy, rom_cs;
    logic [8:0]  hdump, code;
    logic [3:0]  row, pxl;
    logic [7:0]  xpos;
    logic [13:0] rom_addr;
    logic [31:0] rom_data;

    int          passed = 0;
    int          total  = 0;
    logic [3:0]  model [2][256];
    bit          mbank;
    logic [31:0] lw, rw;

    jtyiear_obj_draw #(.HOFFSET(HOFF), .ERASE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .hinit(hinit), .LHBL(LHBL),
        .hdump(hdump), .flip(flip), .draw(draw), .code(code), .row(row), .xpos(xpos),
        .hflip(hflip), .vflip(vflip), .busy(busy), .rom_cs(rom_cs), .rom_addr(rom_addr),
        .rom_data(rom_data), .rom_ok(rom_ok), .pxl(pxl)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_hinit();
        hinit = 1'b1;
        @(posedge clk); #1;
        hinit = 1'b0;
        mbank = ~mbank;
    endtask

    task automatic play_line(input bit fl, input bit check);
        logic [7:0] a;
        logic [3:0] e;
        for (int h = 0; h < 256; h++) begin
            hdump   = 9'(h);
            flip    = fl;
            LHBL    = 1'b1;
            pxl_cen = 1'b1;
            @(posedge clk); #1;
            pxl_cen = 1'b0;
            a = 8'(h) ^ {8{fl}};
            e = model[mbank][a];
            model[mbank][a] = 4'd0;
            if (check) begin
                chk($sformatf("pxl@%02h", a), 32'(pxl), 32'(e));
                if (h % 64 == 5) begin
                    @(posedge clk); #1;
                    chk("pxl_hold", 32'(pxl), 32'(e));
                end
            end
        end
        LHBL    = 1'b0;
        pxl_cen = 1'b1;
        hdump   = 9'd0;
        @(posedge clk); #1;
        pxl_cen = 1'b0;
        chk("pxl_blank", 32'(pxl), 32'd0);
    endtask

    task automatic do_draw(input logic [8:0] c, input logic [3:0] r, input logic [7:0] x,
                           input logic hf, input logic vf, input int unsigned lat,
                           input bit ign, input bit abort_it, input bit with_hinit);
        logic [13:0] addrs [$];
        int unsigned cs_cnt, edges, unstable, ni, col;
        bit          prev_cs, done, aborted, wb;
        logic [13:0] prev_addr, e0, e1;
        logic [31:0] w;
        logic [3:0]  n;
        logic [7:0]  xa;
        cs_cnt = 0; edges = 0; unstable = 0;
        prev_cs = 1'b0; done = 1'b0; aborted = 1'b0; prev_addr = '0;
        e0 = {c, r ^ {4{vf}}, hf};
        e1 = {c, r ^ {4{vf}}, ~hf};
        code = c; row = r; xpos = x; hflip = hf; vflip = vf;
        draw = 1'b1;
        if (with_hinit) hinit = 1'b1;
        @(posedge clk); #1;
        draw = 1'b0;
        if (with_hinit) begin
            hinit = 1'b0;
            mbank = ~mbank;
        end
        wb = ~mbank;
        chk("busy_rise", 32'(busy), 32'd1);
        while (!done && edges < 80) begin
            @(posedge clk); #1;
            edges++;
            if (rom_cs && !prev_cs) addrs.push_back(rom_addr);
            if (rom_cs && prev_cs && rom_addr !== prev_addr) unstable++;
            cs_cnt   = rom_cs ? cs_cnt + 1 : 0;
            rom_ok   = rom_cs && (cs_cnt >= lat + 1);
            rom_data = rom_ok ? (rom_addr[0] ? rw : lw) : $urandom;
            prev_cs   = rom_cs;
            prev_addr = rom_addr;
            if (ign && edges == 2) begin
                draw = 1'b1; code = ~c; xpos = x + 8'h55;
            end else if (ign && edges == 3) begin
                draw = 1'b0;
            end
            if (abort_it && rom_cs && cs_cnt == 2) begin
                hinit = 1'b1;
                @(posedge clk); #1;
                hinit  = 1'b0;
                rom_ok = 1'b0;
                mbank  = ~mbank;
                chk("abort_cs", 32'(rom_cs), 32'd0);
                aborted = 1'b1;
            end
            if (!busy) done = 1'b1;
        end
        rom_ok = 1'b0;
        draw   = 1'b0;
        chk("busy_fall", 32'(busy), 32'd0);
        chk("cs_stable", unstable, 32'd0);
        if (!aborted) begin
            chk("busy_len", 32'(edges >= 16 && edges <= 30), 32'd1);
            chk("fetch_count", addrs.size(), 32'd2);
            chk("addr_first", 32'(addrs.size() > 0 ? addrs[0] : 14'h0), 32'(e0));
            chk("addr_second", 32'(addrs.size() > 1 ? addrs[1] : 14'h0), 32'(e1));
            for (int k = 0; k < 16; k++) begin
                col = k % 8;
                w   = (((k / 8) != 0) ^ hf) ? rw : lw;
                ni  = hf ? 7 - col : col;
                n   = w[ni * 4 +: 4];
                xa  = x + HOFF + 8'(k);
                if (n != 4'd0) model[wb][xa] = n;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; pxl_cen = 1'b0; hinit = 1'b0; LHBL = 1'b0; flip = 1'b0;
        draw = 1'b1; code = 9'h1A5; row = 4'd3; xpos = 8'h40; hflip = 1'b0; vflip = 1'b0;
        rom_ok = 1'b0; rom_data = '0; hdump = '0; mbank = 1'b0;
        lw = 32'h87654321; rw = 32'h0FEDCBA9;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 256; i++) model[b][i] = 4'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cs", 32'(rom_cs), 32'd0);
        chk("rst_pxl", 32'(pxl), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        draw  = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 32'd0);

        // clear both banks through playback erase
        pulse_hinit(); play_line(1'b0, 1'b0);
        pulse_hinit(); play_line(1'b0, 1'b0);

        pulse_hinit();
        do_draw(9'h1A5, 4'd3, 8'h40, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        pulse_hinit(); play_line(1'b0, 1'b1);

        pulse_hinit();
        do_draw(9'h1A5, 4'd3, 8'h40, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        pulse_hinit(); play_line(1'b0, 1'b1);

        pulse_hinit();
        do_draw(9'h1A5, 4'd3, 8'h40, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        pulse_hinit(); play_line(1'b1, 1'b1);

        pulse_hinit();
        lw = 32'h11111111; rw = 32'h22222222;
        do_draw(9'h033, 4'd0, 8'hFC, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        lw = 32'h0A0B0C00; rw = 32'h00E000F0;
        do_draw(9'h044, 4'd7, 8'hF8, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        pulse_hinit(); play_line(1'b0, 1'b1);

        pulse_hinit();
        lw = 32'h87654321; rw = 32'h0FEDCBA9;
        do_draw(9'h0F0, 4'd9, 8'h80, 1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b0);
        pulse_hinit(); play_line(1'b0, 1'b1);

        pulse_hinit();
        do_draw(9'h155, 4'd2, 8'h10, 1'b0, 1'b0, 5, 1'b0, 1'b1, 1'b0);
        play_line(1'b0, 1'b1);

        do_draw(9'h0AA, 4'd5, 8'h20, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1);
        pulse_hinit(); play_line(1'b0, 1'b1);
        pulse_hinit(); play_line(1'b0, 1'b1);
        pulse_hinit(); play_line(1'b0, 1'b1);

        for (int l = 0; l < 5; l++) begin
            pulse_hinit();
            for (int d = 0; d < 3; d++) begin
                lw = $urandom; rw = $urandom;
                do_draw(9'($urandom), 4'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                        $urandom_range(1, 4), 1'($urandom), 1'b0, 1'b0);
            end
            pulse_hinit(); play_line(1'($urandom), 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
